// File: rtl/fifo_lib_pkg.sv
// Shared helpers for the sc_fifo read-side stages.
// Lane-mask and counter-width functions used by the upsizer.
package fifo_lib_pkg;

    localparam int MAX_LANES = 64;

    // Width of a counter that indexes 0..ratio-1 (never below one bit)
    function automatic int lane_cnt_width(input int ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

    // Mask with the low cnt lanes set, limited to ratio lanes
    function automatic logic [MAX_LANES-1:0] keep_mask(
        input int cnt,
        input int ratio
    );
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < cnt && i < ratio) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_upsizer.sv
// Pops narrow words from a show-ahead FIFO and packs RATIO
// of them into one wide valid/ready beat; flush emits a partial beat.
module fifo_rd_upsizer
    import fifo_lib_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int OUT_WIDTH  = DATA_WIDTH * RATIO,
    parameter int CNT_WIDTH  = lane_cnt_width(RATIO)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic                  flush_i,
    output logic                  flush_ack_o,
    output logic [OUT_WIDTH-1:0]  m_data_o,
    output logic [RATIO-1:0]      m_keep_o,
    output logic                  m_last_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [CNT_WIDTH-1:0]  lanes_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RATIO - 1);

    logic [DATA_WIDTH-1:0] r_acc [0:RATIO-2];
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_flush_pend;
    logic                  r_flush_ack;
    logic [OUT_WIDTH-1:0]  r_data;
    logic [RATIO-1:0]      r_keep;
    logic                  r_last;
    logic                  r_valid;

    logic                  w_out_free;
    logic                  w_flush_act;
    logic                  w_cnt_last;
    logic                  w_cnt_zero;
    logic                  w_pop;
    logic                  w_flush_done;
    logic [OUT_WIDTH-1:0]  w_full;
    logic [OUT_WIDTH-1:0]  w_part;
    logic [RATIO-1:0]      w_keep;

    assign w_out_free   = !r_valid || m_ready_i;
    assign w_flush_act  = flush_i || r_flush_pend;
    assign w_cnt_last   = (r_cnt == LAST);
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_pop        = !rst_i && !fifo_empty_i && !w_flush_act
                          && (!w_cnt_last || w_out_free);
    assign w_flush_done = w_flush_act && (w_cnt_zero || w_out_free);
    assign w_keep       = RATIO'(keep_mask(int'(r_cnt), RATIO));

    // Assemble full beat (incoming word on top) and zero-padded partial beat
    always_comb begin
        w_full = '0;
        w_part = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            w_full[i*DATA_WIDTH +: DATA_WIDTH] = r_acc[i];
            if (CNT_WIDTH'(i) < r_cnt) begin
                w_part[i*DATA_WIDTH +: DATA_WIDTH] = r_acc[i];
            end
        end
        w_full[(RATIO-1)*DATA_WIDTH +: DATA_WIDTH] = fifo_data_i;
    end

    // Lane capture, output register, flush tracking and handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                r_acc[i] <= '0;
            end
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_flush_ack  <= 1'b0;
            r_data       <= '0;
            r_keep       <= '0;
            r_last       <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_flush_ack <= w_flush_done;
            if (m_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_pop) begin
                if (w_cnt_last) begin
                    r_data  <= w_full;
                    r_keep  <= '1;
                    r_last  <= 1'b0;
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (r_cnt == CNT_WIDTH'(i)) begin
                            r_acc[i] <= fifo_data_i;
                        end
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_flush_done) begin
                r_flush_pend <= 1'b0;
                if (!w_cnt_zero) begin
                    r_data  <= w_part;
                    r_keep  <= w_keep;
                    r_last  <= 1'b1;
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end
            end else if (w_flush_act) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign fifo_rd_o   = w_pop;
    assign flush_ack_o = r_flush_ack;
    assign m_data_o    = r_data;
    assign m_keep_o    = r_keep;
    assign m_last_o    = r_last;
    assign m_valid_o   = r_valid;
    assign lanes_o     = r_cnt;

endmodule

// File: tb/tb_fifo_rd_upsizer.sv
// Self-checking bench for fifo_rd_upsizer (8-bit lanes, ratio 4).
// A queue-based FIFO and a beat scoreboard model the expected stream.
module tb_fifo_rd_upsizer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fifo_rd_o;
    logic [7:0]  fifo_data_i;
    logic        fifo_empty_i;
    logic        flush_i;
    logic        flush_ack_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_keep_o;
    logic        m_last_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [1:0]  lanes_o;

    fifo_rd_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fifo_rd_o    (fifo_rd_o),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .flush_i      (flush_i),
        .flush_ack_o  (flush_ack_o),
        .m_data_o     (m_data_o),
        .m_keep_o     (m_keep_o),
        .m_last_o     (m_last_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .lanes_o      (lanes_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic [7:0] q[$];
    logic [7:0] buf_q[$];
    beat_t      exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_beats = 0;
    logic       gap = 1'b0;
    logic       gap_toggle = 1'b0;
    logic       outstanding = 1'b0;
    logic       last_rd;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void drive_fifo();
        fifo_empty_i = (q.size() == 0) || gap;
        fifo_data_i  = (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    function automatic void push(input logic [7:0] w);
        q.push_back(w);
        drive_fifo();
    endfunction

    function automatic beat_t make_beat(input logic last);
        beat_t b;
        b.data = 32'h0;
        for (int i = 0; i < buf_q.size(); i++) begin
            b.data = b.data + (32'(buf_q[i]) << (8 * i));
        end
        b.keep = 4'((1 << buf_q.size()) - 1);
        b.last = last;
        return b;
    endfunction

    // One clock: check at negedge, model update just after posedge
    task automatic tick();
        logic rd;
        logic fl;
        logic rs;
        beat_t e;
        @(negedge clk_i);
        rd = fifo_rd_o;
        fl = flush_i;
        rs = rst_i;
        chk("rd_when_empty", 64'(rd & fifo_empty_i), 64'd0);
        chk("rd_during_flush", 64'(rd & fl), 64'd0);
        chk("rd_during_reset", 64'(rd & rs), 64'd0);
        if (!rs && !outstanding) begin
            chk("lanes", 64'(lanes_o), 64'(buf_q.size()));
        end
        if (!rs && flush_ack_o) begin
            chk("ack_expected", 64'(outstanding), 64'd1);
            outstanding = 1'b0;
        end
        if (!rs && m_valid_o && m_ready_i) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(m_data_o), 64'hFFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 64'(m_data_o), 64'(e.data));
                chk("beat_keep", 64'(m_keep_o), 64'(e.keep));
                chk("beat_last", 64'(m_last_o), 64'(e.last));
            end
        end
        @(posedge clk_i);
        #1;
        last_rd = rd;
        if (rs) begin
            buf_q.delete();
            exp_q.delete();
            outstanding = 1'b0;
        end else begin
            if (rd && q.size() != 0) begin
                buf_q.push_back(q.pop_front());
                if (buf_q.size() == 4) begin
                    exp_q.push_back(make_beat(1'b0));
                    buf_q.delete();
                end
            end
            if (fl && !outstanding) begin
                outstanding = 1'b1;
                if (buf_q.size() != 0) begin
                    exp_q.push_back(make_beat(1'b1));
                    buf_q.delete();
                end
            end
        end
        if (gap_toggle) gap = ~gap;
        drive_fifo();
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    initial begin
        bit got;
        rst_i     = 1'b1;
        flush_i   = 1'b0;
        m_ready_i = 1'b1;
        drive_fifo();
        tick();
        tick();
        chk("rst_valid", 64'(m_valid_o), 64'd0);
        chk("rst_data", 64'(m_data_o), 64'd0);
        chk("rst_keep", 64'(m_keep_o), 64'd0);
        chk("rst_last", 64'(m_last_o), 64'd0);
        chk("rst_ack", 64'(flush_ack_o), 64'd0);
        chk("rst_lanes", 64'(lanes_o), 64'd0);
        push(8'h11);
        chk("rst_rd", 64'(fifo_rd_o), 64'd0);
        rst_i = 1'b0;

        // 1: four words make one full beat
        push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_rd", 64'(last_rd), 64'd1);
        end
        chk("t1_valid", 64'(m_valid_o), 64'd1);
        chk("t1_data", 64'(m_data_o), 64'h44332211);
        chk("t1_keep", 64'(m_keep_o), 64'hF);
        chk("t1_last", 64'(m_last_o), 64'd0);
        tick();
        chk("t1_valid_drop", 64'(m_valid_o), 64'd0);

        // 2: backpressure holds beat and blocks the completing pop
        m_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) push(8'((i + 1) * 8'h11));
        for (int i = 0; i < 7; i++) tick();
        chk("t2_held", 64'(m_data_o), 64'h44332211);
        chk("t2_lanes", 64'(lanes_o), 64'd3);
        tick();
        chk("t2_no_pop", 64'(last_rd), 64'd0);
        chk("t2_still", 64'(m_data_o), 64'h44332211);
        m_ready_i = 1'b1;
        tick();
        chk("t2_pop88", 64'(last_rd), 64'd1);
        chk("t2_data", 64'(m_data_o), 64'h88776655);
        chk("t2_valid", 64'(m_valid_o), 64'd1);
        tick();

        // 3: flush after two lanes
        push(8'hA1); push(8'hA2);
        tick(); tick();
        push(8'hA3);
        pulse_flush();
        chk("t3_no_pop", 64'(last_rd), 64'd0);
        chk("t3_data", 64'(m_data_o), 64'h0000A2A1);
        chk("t3_keep", 64'(m_keep_o), 64'h3);
        chk("t3_last", 64'(m_last_o), 64'd1);
        chk("t3_ack", 64'(flush_ack_o), 64'd1);
        chk("t3_lanes", 64'(lanes_o), 64'd0);
        tick();
        chk("t3_ack_pulse", 64'(flush_ack_o), 64'd0);

        // 4a: flush of one lane, then flush with nothing buffered
        pulse_flush();
        chk("t4_keep1", 64'(m_keep_o), 64'h1);
        chk("t4_data1", 64'(m_data_o), 64'h000000A3);
        tick();
        pulse_flush();
        chk("t4_empty_valid", 64'(m_valid_o), 64'd0);
        chk("t4_empty_ack", 64'(flush_ack_o), 64'd1);
        tick();
        chk("t4_empty_ack_off", 64'(flush_ack_o), 64'd0);

        // 4b: flush waits for the held beat to be accepted
        m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hC1 + 8'(i));
        for (int i = 0; i < 6; i++) tick();
        chk("t4_lanes1", 64'(lanes_o), 64'd1);
        pulse_flush();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_wait_ack", 64'(flush_ack_o), 64'd0);
        end
        chk("t4_wait_last", 64'(m_last_o), 64'd0);
        chk("t4_wait_data", 64'(m_data_o), 64'hC4C3C2C1);
        m_ready_i = 1'b1;
        tick();
        chk("t4_part_data", 64'(m_data_o), 64'h000000C5);
        chk("t4_part_last", 64'(m_last_o), 64'd1);
        chk("t4_part_ack", 64'(flush_ack_o), 64'd1);
        tick();

        // 5: reset mid-beat drops buffered lanes
        push(8'hD1); push(8'hD2);
        tick(); tick();
        chk("t5_lanes2", 64'(lanes_o), 64'd2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t5_valid", 64'(m_valid_o), 64'd0);
        chk("t5_lanes", 64'(lanes_o), 64'd0);
        for (int i = 0; i < 4; i++) push(8'hB1 + 8'(i));
        for (int i = 0; i < 4; i++) tick();
        chk("t5_data", 64'(m_data_o), 64'hB4B3B2B1);
        tick();

        // 6: empty toggles every other cycle
        n_beats = 0;
        gap_toggle = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(i + 1));
        for (int i = 0; i < 20; i++) tick();
        gap_toggle = 1'b0;
        gap = 1'b0;
        drive_fifo();
        chk("t6_beats", 64'(n_beats), 64'd2);

        // Random traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            if (q.size() < 6 && $urandom_range(0, 1) == 0) begin
                push(8'($urandom));
            end
            m_ready_i = ($urandom_range(0, 3) != 0);
            gap = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 15) == 0);
            drive_fifo();
            tick();
        end
        flush_i = 1'b0;
        gap = 1'b0;
        m_ready_i = 1'b1;
        drive_fifo();
        for (int c = 0; c < 60 && q.size() != 0; c++) tick();
        chk("drain_fifo", 64'(q.size()), 64'd0);
        pulse_flush();
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (!outstanding) got = 1'b1;
            else tick();
        end
        chk("final_ack_seen", 64'(got), 64'd1);
        for (int c = 0; c < 4; c++) tick();
        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
        chk("final_valid", 64'(m_valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
